// File: rtl/stack_pkg.sv
// Shared types and sizes for the operand-stack sequencer.
package stack_pkg;

    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned SP_W        = 3;
    localparam int unsigned DEPTH_W     = 4;
    localparam int unsigned DATA_W      = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_SWAP  = 3'd4,
        OP_OVER  = 3'd5,
        OP_BINOP = 3'd6,
        OP_ROT   = 3'd7
    } stack_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ROT_2 = 1'b1
    } stack_state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer driving an 8x8 two-read/two-write register file.
module stack_ctrl
    import stack_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [DEPTH_W-1:0] depth,
    output logic              empty,
    output logic              full,
    output logic              err,
    output logic [SP_W-1:0]   rf_re_sel_a,
    output logic [SP_W-1:0]   rf_re_sel_b,
    input  logic [DATA_W-1:0] rf_re_data_a,
    input  logic [DATA_W-1:0] rf_re_data_b,
    output logic [SP_W-1:0]   rf_wr_sel_a,
    output logic [SP_W-1:0]   rf_wr_sel_b,
    output logic [DATA_W-1:0] rf_wr_data_a,
    output logic [DATA_W-1:0] rf_wr_data_b,
    output logic              rf_wr_en_a,
    output logic              rf_wr_en_b
);

    stack_state_t        state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                err_q, err_d;

    logic [SP_W-1:0]     sp;
    stack_op_t           op;
    logic                accept_c;
    logic                legal_c;
    logic                rot_go_c;

    // Depth doubles as the stack pointer; index math wraps modulo 8.
    assign sp        = depth_q[SP_W-1:0];
    assign op        = stack_op_t'(cmd_op);
    assign cmd_ready = (state_q == IDLE);
    assign accept_c  = cmd_valid & cmd_ready;
    assign rot_go_c  = accept_c & legal_c & (op == OP_ROT);

    assign tos   = rf_re_data_a;
    assign nos   = rf_re_data_b;
    assign depth = depth_q;
    assign empty = (depth_q == '0);
    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign err   = err_q;

    // Command legality from current depth only.
    always_comb begin
        legal_c = 1'b0;
        case (op)
            OP_NOP:   legal_c = 1'b1;
            OP_PUSH:  legal_c = (depth_q < DEPTH_W'(STACK_DEPTH));
            OP_POP:   legal_c = (depth_q >= DEPTH_W'(1));
            OP_DUP:   legal_c = (depth_q >= DEPTH_W'(1)) && (depth_q < DEPTH_W'(STACK_DEPTH));
            OP_SWAP:  legal_c = (depth_q >= DEPTH_W'(2));
            OP_OVER:  legal_c = (depth_q >= DEPTH_W'(2)) && (depth_q < DEPTH_W'(STACK_DEPTH));
            OP_BINOP: legal_c = (depth_q >= DEPTH_W'(2));
            OP_ROT:   legal_c = (depth_q >= DEPTH_W'(3));
            default:  legal_c = 1'b0;
        endcase
    end

    // Read selects: tos/nos normally, overridden while a rotate is in flight.
    // Kept apart from the write path so read data never feeds back into its own select.
    always_comb begin
        rf_re_sel_a = sp - SP_W'(1);
        rf_re_sel_b = sp - SP_W'(2);
        if (state_q == ROT_2) begin
            rf_re_sel_a = sp - SP_W'(1);
        end else if (rot_go_c) begin
            rf_re_sel_a = sp - SP_W'(2);
            rf_re_sel_b = sp - SP_W'(3);
        end
    end

    // Next-state, depth, hold, error and register-file write controls.
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        hold_d       = hold_q;
        err_d        = 1'b0;
        rf_wr_sel_a  = '0;
        rf_wr_sel_b  = '0;
        rf_wr_data_a = '0;
        rf_wr_data_b = '0;
        rf_wr_en_a   = 1'b0;
        rf_wr_en_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!legal_c) begin
                        err_d = 1'b1;
                    end else begin
                        case (op)
                            OP_PUSH: begin
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp;
                                rf_wr_data_a = cmd_data;
                                depth_d      = depth_q + DEPTH_W'(1);
                            end
                            OP_POP: begin
                                depth_d = depth_q - DEPTH_W'(1);
                            end
                            OP_DUP: begin
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp;
                                rf_wr_data_a = rf_re_data_a;
                                depth_d      = depth_q + DEPTH_W'(1);
                            end
                            OP_SWAP: begin
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp - SP_W'(1);
                                rf_wr_data_a = rf_re_data_b;
                                rf_wr_en_b   = 1'b1;
                                rf_wr_sel_b  = sp - SP_W'(2);
                                rf_wr_data_b = rf_re_data_a;
                            end
                            OP_OVER: begin
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp;
                                rf_wr_data_a = rf_re_data_b;
                                depth_d      = depth_q + DEPTH_W'(1);
                            end
                            OP_BINOP: begin
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp - SP_W'(2);
                                rf_wr_data_a = cmd_data;
                                depth_d      = depth_q - DEPTH_W'(1);
                            end
                            OP_ROT: begin
                                // y moves down to x's slot; x parks in hold.
                                rf_wr_en_a   = 1'b1;
                                rf_wr_sel_a  = sp - SP_W'(3);
                                rf_wr_data_a = rf_re_data_a;
                                hold_d       = rf_re_data_b;
                                state_d      = ROT_2;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ROT_2: begin
                // z moves down to y's slot; held x lands on top.
                rf_wr_en_a   = 1'b1;
                rf_wr_sel_a  = sp - SP_W'(2);
                rf_wr_data_a = rf_re_data_a;
                rf_wr_en_b   = 1'b1;
                rf_wr_sel_b  = sp - SP_W'(1);
                rf_wr_data_b = hold_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, depth, hold and error registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Both write ports must never target the same entry in one cycle.
    a_no_dual_same_addr: assert property (@(posedge clock) disable iff (!reset_n)
        !(rf_wr_en_a && rf_wr_en_b && (rf_wr_sel_a == rf_wr_sel_b)));

endmodule
